// File: rtl/piso_iob.sv
// piso_iob: parallel-in, serial-out transmitter for the IOB serial link.
//
// A WIDTH-bit word is taken over a valid/ready load handshake into a one-word
// holding buffer, then moved into a shift register and sent LSB first, one bit
// per enabled clock. When the next word is already buffered at the moment the
// last bit of the current word retires, it is reloaded on that same edge, so
// consecutive words leave as a gap-free bit stream.
//
// Ports:
//   CLOCK_IOB    in   clock, rising-edge active
//   RES_IOB      in   asynchronous active-low reset
//   EN_IOB       in   shift enable; low freezes the shift path (load still works)
//   LOAD_IOB     in   load request; DAT_IN_IOB valid while high
//   DAT_IN_IOB   in   parallel word to transmit [WIDTH]
//   RDY_IOB      out  holding buffer empty; load accepted on LOAD_IOB & RDY_IOB
//   DAT_OUT_IOB  out  serial data, LSB first; 0 outside a frame
//   FRAME_IOB    out  high while DAT_OUT_IOB carries a valid bit
//   DONE_IOB     out  one-cycle pulse after the last bit of a word retires

module piso_iob #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK_IOB,
  input  logic             RES_IOB,
  input  logic             EN_IOB,
  input  logic             LOAD_IOB,
  input  logic [WIDTH-1:0] DAT_IN_IOB,
  output logic             RDY_IOB,
  output logic             DAT_OUT_IOB,
  output logic             FRAME_IOB,
  output logic             DONE_IOB
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] hbuf_r;
  logic [WIDTH-1:0] hbuf_s;
  logic             hfull_r;
  logic             hfull_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_s;
  logic             done_r;
  logic             done_s;
  logic             accept_s;

  // State and datapath registers; reset discards both buffered and in-flight words.
  always_ff @(posedge CLOCK_IOB or negedge RES_IOB) begin
    if (!RES_IOB) begin
      state_r <= ST_IDLE;
      hbuf_r  <= {WIDTH{1'b0}};
      hfull_r <= 1'b0;
      shreg_r <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      hbuf_r  <= hbuf_s;
      hfull_r <= hfull_s;
      shreg_r <= shreg_s;
      cnt_r   <= cnt_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic: load handshake plus the IDLE/SHIFT transmit sequence.
  always_comb begin
    state_s  = state_r;
    hbuf_s   = hbuf_r;
    hfull_s  = hfull_r;
    shreg_s  = shreg_r;
    cnt_s    = cnt_r;
    done_s   = 1'b0;
    accept_s = LOAD_IOB & ~hfull_r;

    // Accept only into an empty buffer. A transfer out of the buffer needs
    // hfull_r=1, so the two can never happen on the same edge.
    if (accept_s) begin
      hbuf_s  = DAT_IN_IOB;
      hfull_s = 1'b1;
    end else begin
      hbuf_s  = hbuf_r;
    end

    if (EN_IOB) begin
      case (state_r)
        ST_IDLE: begin
          if (hfull_r) begin
            shreg_s = hbuf_r;
            hfull_s = 1'b0;
            cnt_s   = {CW{1'b0}};
            state_s = ST_SHIFT;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (cnt_r == CNT_LAST) begin
            done_s = 1'b1;
            if (hfull_r) begin
              // Back-to-back reload: the next word's bit 0 follows with no gap.
              shreg_s = hbuf_r;
              hfull_s = 1'b0;
              cnt_s   = {CW{1'b0}};
              state_s = ST_SHIFT;
            end else begin
              // Clearing shreg keeps DAT_OUT_IOB low while no frame is active.
              shreg_s = {WIDTH{1'b0}};
              cnt_s   = {CW{1'b0}};
              state_s = ST_IDLE;
            end
          end else begin
            shreg_s = {1'b0, shreg_r[WIDTH-1:1]};
            cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            state_s = ST_SHIFT;
          end
        end
        default: begin
          shreg_s = {WIDTH{1'b0}};
          cnt_s   = {CW{1'b0}};
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Outputs decoded straight from registers; no path from LOAD_IOB to RDY_IOB.
  always_comb begin
    RDY_IOB     = ~hfull_r;
    DAT_OUT_IOB = shreg_r[0];
    FRAME_IOB   = (state_r == ST_SHIFT);
    DONE_IOB    = done_r;
  end

endmodule

// File: tb/tb_piso_iob.sv
// tb_piso_iob: self-checking bench for piso_iob (WIDTH=8).
// Reference model: a queue of bits for the word on the wire and a queue of
// buffered words, stepped once per clock edge and compared every cycle.

module tb_piso_iob;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [W-1:0] din;
  logic         rdy;
  logic         dout;
  logic         frame;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic         m_bits[$];
  logic [W-1:0] m_buf[$];
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         last_acc = 1'b0;

  // observation
  logic cap[$];
  int   done_idx[$];
  int   done_cnt, rdy_low, run_cur, run_max;

  always #5 clk = ~clk;

  piso_iob #(.WIDTH(W)) dut (
    .CLOCK_IOB   (clk),
    .RES_IOB     (rst_n),
    .EN_IOB      (en),
    .LOAD_IOB    (load),
    .DAT_IN_IOB  (din),
    .RDY_IOB     (rdy),
    .DAT_OUT_IOB (dout),
    .FRAME_IOB   (frame),
    .DONE_IOB    (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic q[$]);
    logic [63:0] v;
    v = 64'h0;
    for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
    return v;
  endfunction

  task automatic model_clear();
    m_bits.delete();
    m_buf.delete();
    m_busy = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_start();
    logic [W-1:0] w;
    w = m_buf.pop_front();
    m_bits.delete();
    for (int i = 0; i < W; i++) m_bits.push_back(w[i]);
    m_busy = 1'b1;
  endtask

  task automatic clear_obs();
    cap.delete();
    done_idx.delete();
    done_cnt = 0;
    rdy_low  = 0;
    run_cur  = 0;
    run_max  = 0;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_rdy"},   rdy,   (m_buf.size() == 0) ? 1'b1 : 1'b0);
    chk({ph, "_frame"}, frame, m_busy);
    chk({ph, "_dout"},  dout,  m_busy ? m_bits[0] : 1'b0);
    chk({ph, "_done"},  done,  m_done);
  endtask

  // One clock: drive inputs, advance model on the edge, check #1 later.
  task automatic step(input string ph, input logic e, input logic l, input logic [W-1:0] d);
    logic acc;
    en = e; load = l; din = d;
    @(posedge clk);
    acc    = 1'b0;
    m_done = 1'b0;
    if (!rst_n) begin
      model_clear();
    end else begin
      acc = l && (m_buf.size() == 0);
      if (e) begin
        if (!m_busy) begin
          if (m_buf.size() > 0) model_start();
        end else begin
          void'(m_bits.pop_front());
          if (m_bits.size() == 0) begin
            m_done = 1'b1;
            if (m_buf.size() > 0) model_start();
            else m_busy = 1'b0;
          end
        end
      end
      if (acc) m_buf.push_back(d);
    end
    last_acc = acc;
    #1;
    check_outputs(ph);
    if (frame) begin
      cap.push_back(dout);
      run_cur++;
      if (run_cur > run_max) run_max = run_cur;
    end else begin
      run_cur = 0;
    end
    if (done) begin
      done_cnt++;
      done_idx.push_back(cap.size() - 1);
    end
    if (!rdy) rdy_low++;
  endtask

  // Hold a load request until the model accepts it; returns attempts used.
  task automatic send(input string ph, input logic [W-1:0] w, output int tries);
    tries = 0;
    do begin
      step(ph, 1'b1, 1'b1, w);
      tries++;
    end while (!last_acc && tries < 30);
    chk({ph, "_accept_timeout"}, last_acc, 1'b1);
  endtask

  task automatic run_idle(input string ph);
    int n;
    n = 0;
    while ((m_busy || m_buf.size() > 0) && n < 60) begin
      step(ph, 1'b1, 1'b0, 8'h00);
      n++;
    end
    step(ph, 1'b1, 1'b0, 8'h00);
    chk({ph, "_idle_frame"}, frame, 1'b0);
  endtask

  initial begin
    int t;
    logic [W-1:0] w1, w2;
    logic pend;
    logic [W-1:0] pd;

    // Reset held with a load request pending: nothing may be captured.
    rst_n = 1'b0; en = 1'b0; load = 1'b1; din = 8'hFF;
    model_clear();
    clear_obs();
    #2;
    chk("rst_dout",  dout,  1'b0);
    chk("rst_frame", frame, 1'b0);
    chk("rst_done",  done,  1'b0);
    chk("rst_rdy",   rdy,   1'b1);
    step("rst", 1'b1, 1'b1, 8'hFF);
    step("rst", 1'b1, 1'b1, 8'hFF);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst", 1'b1, 1'b0, 8'h00);

    // Single word.
    clear_obs();
    send("single", 8'hA5, t);
    run_idle("single");
    chk("single_len",  cap.size(), 8);
    chk("single_bits", pack(cap), 8'hA5);
    chk("single_done", done_cnt, 1);
    chk("single_rdy_low", rdy_low, 1);

    // Back-to-back: second word loaded while bit 2 of the first is on the wire.
    clear_obs();
    send("b2b", 8'h3C, t);
    for (int i = 0; i < 3; i++) step("b2b", 1'b1, 1'b0, 8'h00);
    send("b2b", 8'hFF, t);
    chk("b2b_load_tries", t, 1);
    run_idle("b2b");
    chk("b2b_len",   cap.size(), 16);
    chk("b2b_run",   run_max, 16);
    chk("b2b_bits",  pack(cap), 16'hFF3C);
    chk("b2b_done",  done_cnt, 2);
    chk("b2b_done0_at_bit0", done_idx[0], 8);

    // Stall: 3 disabled cycles after bit 3, with a load accepted mid-stall.
    clear_obs();
    send("stall", 8'h96, t);
    for (int i = 0; i < 4; i++) step("stall", 1'b1, 1'b0, 8'h00);
    step("stall", 1'b0, 1'b1, 8'h11);
    chk("stall_load_acc", last_acc, 1'b1);
    step("stall", 1'b0, 1'b0, 8'h00);
    step("stall", 1'b0, 1'b0, 8'h00);
    run_idle("stall");
    // 0,1,1,0,[0,0,0],1,0,0,1 then 1,0,0,0,1,0,0,0 packed LSB first
    chk("stall_len",  cap.size(), 19);
    chk("stall_bits", pack(cap), 64'h8C86);
    chk("stall_done", done_cnt, 2);
    chk("stall_done0_idx", done_idx[0], 11);

    // Full buffer: third word held on LOAD until the buffer frees up.
    clear_obs();
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    send("full", w1, t);
    send("full", w2, t);
    chk("full_w2_tries", t, 2);
    send("full", 8'h5A, t);
    chk("full_5a_tries", t, 8);
    run_idle("full");
    chk("full_len",  cap.size(), 24);
    chk("full_bits", pack(cap), {40'h0, 8'h5A, w2, w1});
    chk("full_done", done_cnt, 3);

    // Async reset mid-word, between edges.
    clear_obs();
    send("arst", 8'hF0, t);
    for (int i = 0; i < 5; i++) step("arst", 1'b1, 1'b0, 8'h00);
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    chk("arst_dout",  dout,  1'b0);
    chk("arst_frame", frame, 1'b0);
    chk("arst_done",  done,  1'b0);
    chk("arst_rdy",   rdy,   1'b1);
    clear_obs();
    step("arst_hold", 1'b1, 1'b0, 8'h00);
    step("arst_hold", 1'b1, 1'b0, 8'h00);
    #2 rst_n = 1'b1;
    send("arst_after", 8'h01, t);
    chk("arst_after_tries", t, 1);
    run_idle("arst_after");
    chk("arst_after_len",  cap.size(), 8);
    chk("arst_after_bits", pack(cap), 8'h01);
    chk("arst_after_done", done_cnt, 1);

    // Randomized traffic with holding upstream and occasional resets.
    pend = 1'b0;
    pd   = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if (!pend && $urandom_range(0, 9) < 4) begin
        pend = 1'b1;
        pd   = 8'($urandom);
      end
      rst_n = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      step("rand", ($urandom_range(0, 3) != 0), pend, pend ? pd : 8'($urandom));
      if (last_acc || !rst_n) pend = 1'b0;
    end
    rst_n = 1'b1;
    run_idle("rand_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piso_iob.md
# piso_iob

Parallel-in, serial-out transmitter for the IOB serial link. It accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out LSB first, one bit per enabled clock. A one-word holding buffer lets upstream queue the next word while the current one is shifting, so consecutive words leave as a gap-free bit stream. It is the transmit end feeding the IOB serial-in/parallel-out receiver, which reassembles bits in the same LSB-first order.

## Interface
- WIDTH, 8, word length in bits; legal range 2..64
- CLOCK_IOB  in  1  clock; all state changes on its rising edge
- RES_IOB  in  1  reset, asynchronous, active-low
- EN_IOB  in  1  shift enable; low freezes the shift path
- LOAD_IOB  in  1  load request; DAT_IN_IOB is valid while high
- DAT_IN_IOB  in  WIDTH  parallel word to transmit
- RDY_IOB  out  1  holding buffer empty; a load is accepted when LOAD_IOB & RDY_IOB
- DAT_OUT_IOB  out  1  serial data, LSB first
- FRAME_IOB  out  1  high while DAT_OUT_IOB carries a valid bit
- DONE_IOB  out  1  one-cycle pulse after the last bit of a word retires

## Operation
- State: holding buffer hbuf[WIDTH] with flag hfull; shift register shreg[WIDTH]; bit counter cnt of width clog2(WIDTH); FSM {IDLE, SHIFT}.
- RDY_IOB = ~hfull, driven directly from the register with no combinational path from LOAD_IOB.
- Accept on an edge where LOAD_IOB & RDY_IOB: hbuf <= DAT_IN_IOB, hfull <= 1. The accept is independent of EN_IOB.
- When LOAD_IOB is high and RDY_IOB is low, nothing is captured. Upstream holds the word until it is accepted.
- IDLE, on an edge with EN_IOB=1 and hfull=1: shreg <= hbuf, hfull <= 0, cnt <= 0, go to SHIFT.
- SHIFT, on an edge with EN_IOB=1 and cnt < WIDTH-1: shreg <= shreg >> 1, cnt <= cnt+1.
- SHIFT, on an edge with EN_IOB=1 and cnt = WIDTH-1: DONE_IOB <= 1 for that one cycle.
  - If hfull=1: reload shreg from hbuf, clear hfull, set cnt <= 0, stay in SHIFT. This gives a back-to-back word with no idle bit.
  - Otherwise: shreg <= 0 and go to IDLE.
- EN_IOB=0: shreg, cnt, state and DAT_OUT_IOB hold, and no DONE pulse occurs. The load handshake still operates.
- DAT_OUT_IOB = shreg[0]. FRAME_IOB = (state == SHIFT). DAT_OUT_IOB is 0 whenever FRAME_IOB is 0.
- A load and a buffer-to-shreg transfer cannot coincide, because the transfer only happens when hfull=1 and so RDY_IOB=0.
- RES_IOB low clears immediately, regardless of clock: state=IDLE, hfull=0, shreg=0, cnt=0, DONE_IOB=0. Both the in-flight word and the buffered word are discarded, and no DONE pulse is produced for them.

## Timing
- Reset values: DAT_OUT_IOB=0, FRAME_IOB=0, DONE_IOB=0, RDY_IOB=1.
- From accept at edge k while IDLE with EN_IOB=1:
  - RDY_IOB is low for the cycle after edge k.
  - Bit 0 and FRAME_IOB appear after edge k+1.
  - RDY_IOB returns high after edge k+1.
- A word occupies exactly WIDTH enabled cycles of FRAME_IOB. Each disabled cycle stretches the frame by one.
- DONE_IOB is high for the single cycle following the edge that retires bit WIDTH-1. In back-to-back operation it coincides with bit 0 of the next word.
- Sustained throughput is one bit per enabled clock, provided upstream reloads during the WIDTH-cycle window.
- Release of RES_IOB is synchronous-safe. The first accept is possible on the first edge after release.

## Test plan
- Reset: assert RES_IOB low with LOAD_IOB=1 -> DAT_OUT_IOB=0, FRAME_IOB=0, DONE_IOB=0, RDY_IOB=1; nothing is captured.
- Single word, WIDTH=8, load 8'hA5 with EN_IOB=1 -> DAT_OUT_IOB sequence 1,0,1,0,0,1,0,1 over 8 FRAME_IOB cycles; RDY_IOB low exactly 1 cycle; one DONE_IOB pulse after the 8th bit; then idle.
- Back-to-back: load 8'h3C, then load 8'hFF during bit 2 of the first word:
  - FRAME_IOB is high for 16 consecutive cycles.
  - The stream is 0,0,1,1,1,1,0,0 followed by eight 1s.
  - Two DONE_IOB pulses, the first aligned with bit 0 of 8'hFF.
- Stall: 8'h96 with EN_IOB held low for 3 cycles after bit 3:
  - DAT_OUT_IOB and FRAME_IOB hold during the stall.
  - The frame lasts 11 cycles; the bit sequence 0,1,1,0,1,0,0,1 is unchanged.
  - A load of 8'h11 during the stall is accepted and sent next.
- Full buffer: with a word shifting and a word buffered, hold LOAD_IOB=1 with 8'h5A -> not accepted while RDY_IOB=0. It is captured on the first edge with RDY_IOB=1 and transmitted third, intact.
- Async reset mid-word: drop RES_IOB between edges during bit 4 of 8'hF0:
  - Outputs go to their reset values before the next edge.
  - No DONE_IOB pulse.
  - After release, a new load of 8'h01 transmits 1,0,0,0,0,0,0,0 normally.
